// File: rtl/apb_master_mux.sv
// apb_master_mux
//   APB3 (+PSTRB) master that turns a single outstanding valid/ready request
//   into one APB transfer to one of NUM_SLAVES completers, then returns the
//   result on a valid/ready response port. The completer index comes from
//   the top SEL_BITS address bits. Indices at or above NUM_SLAVES answer
//   with an error and never touch the bus.
//
//   Optional build macro: APB_TIMEOUT_EN
//     When defined, an ACCESS phase that waits TIMEOUT_CYCLES cycles with
//     PREADY low is aborted and answered with an error. When undefined,
//     ACCESS waits indefinitely.
//
// Ports
//   PCLK, PRESET            clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake; req_write/addr/wdata/strb payload
//   rsp_valid/rsp_ready     response handshake; rsp_rdata/rsp_err payload
//   PSEL..PSTRB             registered APB master outputs
//   PRDATA/PREADY/PSLVERR   per-completer return signals (concatenated)

module apb_master_mux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      req_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_d;
  logic [NUM_SLAVES-1:0]     psel_d;
  logic                      penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]     paddr_d;
  logic [DATA_WIDTH-1:0]     pwdata_d;
  logic [DATA_WIDTH/8-1:0]   pstrb_d;

  logic [SEL_BITS-1:0]       req_idx;
  logic                      decode_ok;
  logic [DATA_WIDTH-1:0]     sel_rdata;
  logic                      sel_ready, sel_err;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign req_idx   = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
  // Extra bit so NUM_SLAVES == 2**SEL_BITS still compares correctly.
  assign decode_ok = {1'b0, req_idx} < (SEL_BITS+1)'(NUM_SLAVES);

  // PSEL is one-hot during SETUP/ACCESS, so it doubles as the return mux
  // select; signals from unselected completers never reach the FSM.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) begin
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          pstrb_d     = req_write ? req_strb : '0;
          if (decode_ok) begin
            state_d = SETUP;
            for (int i = 0; i < NUM_SLAVES; i++) begin
              psel_d[i] = (req_idx == SEL_BITS'(i));
            end
            penable_d = 1'b0;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!PWRITE && !sel_err) ? sel_rdata : '0;
        end
`ifdef APB_TIMEOUT_EN
        // The increment that would reach TIMEOUT_CYCLES aborts instead.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from flops; reset drops the bus immediately.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// tb_apb_master_mux
//   Directed bench for apb_master_mux with four completers. Completer
//   return signals are driven directly from the stimulus sequence; every
//   expected value below is hand-derived from the transfer timing.

module tb_apb_master_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic            req_valid, req_ready, req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_strb;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [NS-1:0]   PSEL;
  logic            PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]   PREADY, PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_master_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .SEL_BITS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Every step lands 1 time unit after a rising edge: outputs are settled
  // and inputs set here are stable well before the next edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata,
                               input logic [DW/8-1:0] strb);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b1;
    PRDATA = '0; PREADY = '0; PSLVERR = '0;
    step(); step();
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_paddr", PADDR, 0);
    PRESET = 1'b0;
    step();

    // Write to completer 1; other completers' PSLVERR must be ignored.
    $display("[TB] write to completer 1");
    PREADY = 4'b1111; PSLVERR = 4'b1101;
    applyStimulus(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF);
    step();
    req_valid = 1'b0;
    checkOutput("wr_psel_c1", PSEL, 4'b0010);
    checkOutput("wr_penable_c1", PENABLE, 0);
    checkOutput("wr_req_ready_c1", req_ready, 0);
    checkOutput("wr_pwdata", PWDATA, 32'hDEAD_BEEF);
    checkOutput("wr_paddr", PADDR, 32'h1000_0040);
    checkOutput("wr_pstrb", PSTRB, 4'hF);
    checkOutput("wr_pwrite", PWRITE, 1);
    step();
    checkOutput("wr_penable_c2", PENABLE, 1);
    checkOutput("wr_psel_c2", PSEL, 4'b0010);
    checkOutput("wr_rsp_valid_c2", rsp_valid, 0);
    step();
    checkOutput("wr_rsp_valid_c3", rsp_valid, 1);
    checkOutput("wr_rsp_err", rsp_err, 0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 0);
    checkOutput("wr_psel_c3", PSEL, 0);
    checkOutput("wr_penable_c3", PENABLE, 0);
    step();
    checkOutput("wr_rsp_valid_c4", rsp_valid, 0);
    checkOutput("wr_req_ready_c4", req_ready, 1);

    // Read from completer 3 with three wait states.
    $display("[TB] read completer 3 with wait states");
    PSLVERR = 4'b0000; PREADY = 4'b0111;
    PRDATA[0*DW +: DW] = 32'hAAAA_AAAA;
    PRDATA[3*DW +: DW] = 32'h1234_5678;
    applyStimulus(1'b0, 32'h3000_0000, 32'h5555_5555, 4'hF);
    step();
    req_valid = 1'b0;
    checkOutput("rd_psel", PSEL, 4'b1000);
    checkOutput("rd_pstrb_forced0", PSTRB, 0);
    checkOutput("rd_pwrite", PWRITE, 0);
    step();
    checkOutput("rd_penable_c2", PENABLE, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rd_wait_penable", PENABLE, 1);
      checkOutput("rd_wait_psel", PSEL, 4'b1000);
      checkOutput("rd_wait_rsp_valid", rsp_valid, 0);
    end
    PREADY = 4'b1111;
    step();
    checkOutput("rd_rsp_valid_c6", rsp_valid, 1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    checkOutput("rd_rsp_err", rsp_err, 0);
    checkOutput("rd_penable_off", PENABLE, 0);
    step();

    // Read from completer 2 that reports an error.
    $display("[TB] read completer 2 with slave error");
    PSLVERR = 4'b0100;
    PRDATA[2*DW +: DW] = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 32'h2000_0000, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    checkOutput("err_psel", PSEL, 4'b0100);
    step(); step();
    checkOutput("err_rsp_valid", rsp_valid, 1);
    checkOutput("err_rsp_err", rsp_err, 1);
    checkOutput("err_rsp_rdata", rsp_rdata, 0);
    step();
    PSLVERR = 4'b0000;

    // Out-of-range completer index: no bus activity, immediate error.
    $display("[TB] decode error");
    applyStimulus(1'b0, 32'h7000_0000, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    checkOutput("dec_rsp_valid_c1", rsp_valid, 1);
    checkOutput("dec_rsp_err", rsp_err, 1);
    checkOutput("dec_rsp_rdata", rsp_rdata, 0);
    checkOutput("dec_psel", PSEL, 0);
    step();
    checkOutput("dec_req_ready", req_ready, 1);
    checkOutput("dec_psel_after", PSEL, 0);

    // Back-to-back requests with a stalled response consumer.
    $display("[TB] back-to-back with response backpressure");
    rsp_ready = 1'b0;
    PRDATA[1*DW +: DW] = 32'hCAFE_F00D;
    applyStimulus(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'h3);
    step();
    checkOutput("b2b_psel_first", PSEL, 4'b0001);
    applyStimulus(1'b0, 32'h1000_0004, 32'h0, 4'h0);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("b2b_hold_rsp_valid", rsp_valid, 1);
      checkOutput("b2b_hold_rsp_err", rsp_err, 0);
      checkOutput("b2b_hold_rsp_rdata", rsp_rdata, 0);
      checkOutput("b2b_hold_req_ready", req_ready, 0);
      checkOutput("b2b_hold_psel", PSEL, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    checkOutput("b2b_rsp_done", rsp_valid, 0);
    checkOutput("b2b_req_ready", req_ready, 1);
    checkOutput("b2b_paddr_hold", PADDR, 32'h0000_0010);
    checkOutput("b2b_pwdata_hold", PWDATA, 32'h0BAD_F00D);
    step();
    req_valid = 1'b0;
    checkOutput("b2b_psel_second", PSEL, 4'b0010);
    checkOutput("b2b_paddr_second", PADDR, 32'h1000_0004);
    checkOutput("b2b_req_ready_second", req_ready, 0);
    step(); step();
    checkOutput("b2b_rsp_valid_second", rsp_valid, 1);
    checkOutput("b2b_rdata_second", rsp_rdata, 32'hCAFE_F00D);
    step();

    // Reset pulse during ACCESS aborts the transfer without an edge.
    $display("[TB] reset during access");
    PREADY = 4'b0000;
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    step(); step();
    checkOutput("rstmid_penable_before", PENABLE, 1);
    PRESET = 1'b1;
    #1;
    checkOutput("rstmid_psel", PSEL, 0);
    checkOutput("rstmid_penable", PENABLE, 0);
    checkOutput("rstmid_rsp_valid", rsp_valid, 0);
    checkOutput("rstmid_req_ready", req_ready, 1);
    #1;
    PRESET = 1'b0;
    step();
    checkOutput("rstmid_req_ready_after", req_ready, 1);
    checkOutput("rstmid_psel_after", PSEL, 0);

`ifdef APB_TIMEOUT_EN
    // PREADY stuck low: eight waiting ACCESS cycles, then an error response.
    $display("[TB] access timeout");
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput("to_wait_penable", PENABLE, 1);
      checkOutput("to_wait_rsp_valid", rsp_valid, 0);
    end
    step();
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_rsp_err", rsp_err, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    checkOutput("to_psel", PSEL, 0);
    PREADY = 4'b1111;
    step();
    checkOutput("to_rsp_done", rsp_valid, 0);
    checkOutput("to_req_ready", req_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
